// File: rtl/byte_coder_if.sv
// Upstream-to-coder byte handshake plus the serial line and status outputs.
`timescale 1ns/1ps
interface byte_coder_if;
  logic [7:0] d;
  logic       d_rdy;
  logic       msg_end;
  logic       tx;
  logic       busy;
  logic       bit_stb;

  modport master (output d, d_rdy, msg_end, input tx, busy, bit_stb);
  modport slave  (input d, d_rdy, msg_end, output tx, busy, bit_stb);
endinterface

// File: rtl/byte_coder.sv
// Serial byte coder: start, 8 data bits LSB first, parity, stop, then an
// optional idle gap after a message ends. All outputs are registered.
`timescale 1ns/1ps
module byte_coder #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_BITS   = 2,
  parameter int PARITY_ODD = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  byte_coder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_BITS - 1);

  state_t     state_reg;
  logic [7:0] div_reg;
  logic [2:0] bit_idx_reg;
  logic [7:0] shift_reg;
  logic [3:0] gap_cnt_reg;
  logic       gap_pend_reg;
  logic       tx_reg;
  logic       busy_reg;
  logic       bit_stb_reg;

  logic bit_end;
  logic parity_bit;
  logic gap_req;

  assign bit_end    = (div_reg == 8'd0);
  assign parity_bit = (^shift_reg) ^ (PARITY_ODD != 0);
  // A msg_end arriving on the very cycle STOP finishes still counts.
  assign gap_req    = gap_pend_reg | bus.msg_end;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      div_reg      <= 8'd0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      gap_cnt_reg  <= 4'd0;
      gap_pend_reg <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      bit_stb_reg  <= 1'b0;
    end else begin
      if (bus.msg_end) gap_pend_reg <= 1'b1;
      bit_stb_reg <= 1'b0;
      if (state_reg != IDLE) begin
        if (bit_end) begin
          div_reg     <= DIV_LOAD;
          bit_stb_reg <= 1'b1;
        end else begin
          div_reg <= div_reg - 8'd1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (bus.d_rdy) begin
            shift_reg   <= bus.d;
            state_reg   <= START;
            tx_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            bit_stb_reg <= 1'b1;
            div_reg     <= DIV_LOAD;
          end else if (gap_req) begin
            state_reg    <= GAP;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b1;
            bit_stb_reg  <= 1'b1;
            div_reg      <= DIV_LOAD;
            gap_cnt_reg  <= GAP_LOAD;
            gap_pend_reg <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_reg   <= DATA;
            bit_idx_reg <= 3'd0;
            tx_reg      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= PARITY;
              tx_reg    <= parity_bit;
            end else begin
              tx_reg <= shift_reg[bit_idx_reg + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (gap_req) begin
              state_reg    <= GAP;
              gap_cnt_reg  <= GAP_LOAD;
              gap_pend_reg <= 1'b0;
            end else begin
              state_reg   <= IDLE;
              busy_reg    <= 1'b0;
              bit_stb_reg <= 1'b0;
              div_reg     <= 8'd0;
            end
          end
        end
        GAP: begin
          if (bit_end) begin
            if (gap_cnt_reg == 4'd0) begin
              state_reg   <= IDLE;
              busy_reg    <= 1'b0;
              bit_stb_reg <= 1'b0;
              div_reg     <= 8'd0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - 4'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.tx      = tx_reg;
  assign bus.busy    = busy_reg;
  assign bus.bit_stb = bit_stb_reg;

endmodule

// File: tb/tb_byte_coder.sv
// Directed bench for byte_coder: odd-parity DUT plus an even-parity twin
// driven by the same stimulus.
`timescale 1ns/1ps
module tb_byte_coder;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int busy_total = 0;
  int stb_total = 0;

  byte_coder_if bus ();
  byte_coder_if bus_e ();

  assign bus_e.d       = bus.d;
  assign bus_e.d_rdy   = bus.d_rdy;
  assign bus_e.msg_end = bus.msg_end;

  byte_coder #(.CLK_DIV(4), .GAP_BITS(2), .PARITY_ODD(1)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus.slave));
  byte_coder #(.CLK_DIV(4), .GAP_BITS(2), .PARITY_ODD(0)) dut_e (
    .clk(clk), .n_rst(n_rst), .bus(bus_e.slave));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.busy) busy_total++;
    if (bus.bit_stb) stb_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the gap-entry edge.
  task automatic gap_chk(input string tag);
    for (int c = 0; c < 8; c++) begin
      chk({tag, " gap tx/busy"}, {30'd0, bus.tx, bus.busy}, 32'd3);
      if (c == 4) chk({tag, " gap stb"}, {31'd0, bus.bit_stb}, 32'd1);
      tick();
    end
    chk({tag, " gap end busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " gap end stb"}, {31'd0, bus.bit_stb}, 32'd0);
  endtask

  // Called right after the accepting edge; checks every bit of one frame.
  task automatic frame_chk(input string tag, input logic [7:0] val, input logic par,
                           input int me_at, input bit gap);
    logic [10:0] bits;
    int b0, s0;
    b0 = busy_total;
    s0 = stb_total;
    bits = {1'b1, par, val, 1'b0};
    chk({tag, " busy rise"}, {31'd0, bus.busy}, 32'd1);
    for (int c = 0; c < 44; c++) begin
      if (c % 4 == 0) begin
        chk({tag, " tx"}, {31'd0, bus.tx}, {31'd0, bits[c / 4]});
        chk({tag, " tx even"}, {31'd0, bus_e.tx},
            {31'd0, (c / 4 == 9) ? ~par : bits[c / 4]});
        chk({tag, " stb"}, {31'd0, bus.bit_stb}, 32'd1);
      end
      if (c == 1) chk({tag, " stb low"}, {31'd0, bus.bit_stb}, 32'd0);
      bus.msg_end = (c == me_at);
      tick();
    end
    bus.msg_end = 1'b0;
    chk({tag, " busy cycles"}, 32'(busy_total - b0), 32'd44);
    chk({tag, " stb count"}, 32'(stb_total - s0), 32'd11);
    if (gap) begin
      chk({tag, " gap entry"}, {29'd0, bus.tx, bus.busy, bus.bit_stb}, 32'd7);
      gap_chk(tag);
    end else begin
      chk({tag, " busy end"}, {31'd0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    bus.d = 8'h00;
    bus.d_rdy = 1'b0;
    bus.msg_end = 1'b0;
    n_rst = 1'b0;
    repeat (3) tick();
    chk("reset outs", {29'd0, bus.tx, bus.busy, bus.bit_stb}, 32'd4);
    chk("reset outs even", {29'd0, bus_e.tx, bus_e.busy, bus_e.bit_stb}, 32'd4);
    n_rst = 1'b1;
    repeat (2) tick();
    chk("idle no stb", {29'd0, bus.tx, bus.busy, bus.bit_stb}, 32'd4);

    // 0xA5: parity 1 (odd)
    bus.d = 8'hA5; bus.d_rdy = 1'b1;
    tick();
    bus.d_rdy = 1'b0; bus.d = 8'h00;
    frame_chk("a5", 8'hA5, 1'b1, -1, 1'b0);
    tick();

    // 0x00 -> parity 1, 0x01 -> parity 0
    bus.d = 8'h00; bus.d_rdy = 1'b1;
    tick();
    bus.d_rdy = 1'b0;
    frame_chk("00", 8'h00, 1'b1, -1, 1'b0);
    tick();
    bus.d = 8'h01; bus.d_rdy = 1'b1;
    tick();
    bus.d_rdy = 1'b0;
    frame_chk("01", 8'h01, 1'b0, -1, 1'b0);
    tick();

    // back-to-back with d changing after acceptance
    bus.d = 8'h3C; bus.d_rdy = 1'b1;
    tick();
    bus.d = 8'hFF;
    frame_chk("b2b 3c", 8'h3C, 1'b1, -1, 1'b0);
    tick();
    bus.d = 8'h12;
    bus.d_rdy = 1'b0;
    frame_chk("b2b ff", 8'hFF, 1'b1, -1, 1'b0);
    tick();

    // msg_end at cycle 10 of a frame
    bus.d = 8'h81; bus.d_rdy = 1'b1;
    tick();
    bus.d_rdy = 1'b0;
    frame_chk("msgend mid", 8'h81, 1'b1, 10, 1'b1);
    tick();

    // d_rdy and msg_end together
    bus.d = 8'h7E; bus.d_rdy = 1'b1; bus.msg_end = 1'b1;
    tick();
    bus.d_rdy = 1'b0; bus.msg_end = 1'b0;
    frame_chk("rdy+end", 8'h7E, 1'b1, -1, 1'b1);
    tick();

    // msg_end alone: gap only, no start bit
    bus.msg_end = 1'b1;
    tick();
    bus.msg_end = 1'b0;
    chk("gap only entry", {29'd0, bus.tx, bus.busy, bus.bit_stb}, 32'd7);
    gap_chk("gap only");
    tick();

    // reset during DATA bit 3, d_rdy held through reset
    bus.d = 8'h5A; bus.d_rdy = 1'b1;
    tick();
    bus.d_rdy = 1'b0;
    repeat (17) tick();
    chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    n_rst = 1'b0;
    bus.d = 8'h33; bus.d_rdy = 1'b1;
    tick();
    chk("abort outs", {29'd0, bus.tx, bus.busy, bus.bit_stb}, 32'd4);
    n_rst = 1'b1;
    tick();
    bus.d_rdy = 1'b0;
    frame_chk("post reset", 8'h33, 1'b1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/byte_coder.md
BYTE_CODER -- requirements
Module: byte_coder

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clk cycles per serial bit, legal range 2..255.
REQ-002 The block SHALL have parameter GAP_BITS, default 2: idle bit periods inserted after a message end, legal range 1..15.
REQ-003 The block SHALL have parameter PARITY_ODD, default 1: 1 selects odd parity, 0 selects even parity.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 n_rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 d  input  8  byte to send, from the upstream message controller (its q).
REQ-007 d_rdy  input  1  level: byte on d is valid (upstream q_rdy).
REQ-008 msg_end  input  1  level/pulse: current message is finished.
REQ-009 tx  output  1  serial line; idles high.
REQ-010 busy  output  1  coder occupied (feeds upstream cd_busy).
REQ-011 bit_stb  output  1  one-cycle pulse at the first clk of every transmitted bit period.

Function
REQ-012 FSM states SHALL be: IDLE, START, DATA, PARITY, STOP, GAP.
REQ-013 In IDLE with d_rdy=1, the block SHALL latch d into a shift register, set busy=1 and enter START on the next edge.
REQ-014 Each bit SHALL last exactly CLK_DIV cycles, timed by a divider counter that reloads at every bit boundary.
REQ-015 START SHALL drive tx=0 for one bit period.
REQ-016 DATA SHALL drive 8 bits LSB first, using a 3-bit index that wraps 7->0 on exit to PARITY.
REQ-017 PARITY SHALL drive the XOR of the 8 data bits, inverted when PARITY_ODD=1.
REQ-018 STOP SHALL drive tx=1 for one bit period.
REQ-019 At the end of STOP, the block SHALL go to GAP if gap_pend=1, else to IDLE with busy=0.
REQ-020 A frame SHALL occupy 11*CLK_DIV cycles of busy=1.
REQ-021 busy SHALL be 0 in IDLE only, so busy stays low for at least 1 cycle between frames and upstream sees a fresh rising edge per byte.
REQ-022 d and d_rdy SHALL be ignored outside IDLE; changes to d mid-frame SHALL NOT affect the frame in flight.
REQ-023 msg_end=1 on any cycle SHALL set gap_pend; gap_pend SHALL be cleared on entering GAP.
REQ-024 In IDLE with msg_end=1 and d_rdy=0, the block SHALL enter GAP directly with busy=1.
REQ-025 In IDLE with d_rdy=1 and msg_end=1 on the same cycle, the byte SHALL be sent first, then GAP follows its STOP.
REQ-026 GAP SHALL hold tx=1 and busy=1 for GAP_BITS*CLK_DIV cycles, then go to IDLE.
REQ-027 msg_end asserted during GAP SHALL set gap_pend again, giving one more GAP after IDLE is reached; it SHALL NOT extend the current gap.
REQ-028 bit_stb SHALL pulse in START, DATA, PARITY, STOP and GAP bit periods only; never in IDLE.

Reset
REQ-029 With n_rst=0 at a clk edge, the block SHALL next have: state=IDLE, tx=1, busy=0, bit_stb=0, gap_pend=0, divider=0, bit index=0, shift register=0.
REQ-030 Reset mid-frame SHALL abort the frame immediately with no stop bit, and tx SHALL return high on that edge.
REQ-031 d_rdy held high during reset SHALL be accepted on the first edge after n_rst=1.

Verification (CLK_DIV=4, GAP_BITS=2, PARITY_ODD=1)
REQ-032 d=0xA5, d_rdy pulse in IDLE -> tx per bit 0,1,0,1,0,0,1,0,1,1,1 (parity=1); busy high for exactly 44 cycles; 11 bit_stb pulses.
REQ-033 d=0x00 -> parity bit 1; d=0x01 -> parity bit 0; with PARITY_ODD=0 both results invert.
REQ-034 d_rdy held high continuously, d changed after acceptance -> back-to-back frames each carry the value latched at acceptance; busy low exactly 1 cycle between frames.
REQ-035 msg_end pulse at cycle 10 of a frame -> after STOP, 8 cycles of tx=1 with busy=1, then IDLE.
REQ-036 d_rdy and msg_end together in IDLE -> full frame, then 8-cycle gap; msg_end alone in IDLE -> 8-cycle gap, no start bit.
REQ-037 n_rst=0 during the DATA bit-3 period -> next cycle tx=1, busy=0; a new byte after reset transmits cleanly.
